// File: rtl/bcd_arb_pkg.sv
// Shared types and widths for the round-robin BCD conversion arbiter.
package bcd_arb_pkg;
  localparam int BIN_W    = 8;
  localparam int BCD_W    = 12;
  localparam int CONV_LAT = 3;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
endpackage

// File: rtl/bcd8_core.sv
// Three-stage 8-bit binary to 3-digit BCD converter with start/done handshake.
module bcd8_core
  import bcd_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             done,
  output logic [BCD_W-1:0] result
);
  logic             vld_p0, vld_p1, vld_p2;
  logic [1:0]       hund_p0, hund_p1;
  logic [6:0]       rem_p0;
  logic [3:0]       tens_p1;
  logic [5:0]       ones_p1;
  logic [BCD_W-1:0] res_p2;

  logic       take;
  logic [1:0] hund_c;
  logic [6:0] rem_c;
  logic [5:0] ones_c;
  logic [2:0] q_c;
  logic [3:0] tens_c, ones_fix_c;

  assign take = start && !(vld_p0 || vld_p1 || vld_p2);

  always_comb begin
    hund_c = 2'd0;
    rem_c  = operand[6:0];
    if (operand >= 8'd200) begin
      hund_c = 2'd2;
      rem_c  = 7'(operand - 8'd200);
    end else if (operand >= 8'd100) begin
      hund_c = 2'd1;
      rem_c  = 7'(operand - 8'd100);
    end
    // Each binary 16 in the remainder is one ten plus six ones.
    ones_c = 6'({rem_p0[6:4], 2'b00}) + 6'({rem_p0[6:4], 1'b0}) + 6'(rem_p0[3:0]);
    if (ones_p1 >= 6'd40)      q_c = 3'd4;
    else if (ones_p1 >= 6'd30) q_c = 3'd3;
    else if (ones_p1 >= 6'd20) q_c = 3'd2;
    else if (ones_p1 >= 6'd10) q_c = 3'd1;
    else                       q_c = 3'd0;
    tens_c     = tens_p1 + 4'(q_c);
    ones_fix_c = 4'(ones_p1 - 6'(q_c) * 6'd10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      hund_p0 <= '0;
      rem_p0  <= '0;
      hund_p1 <= '0;
      tens_p1 <= '0;
      ones_p1 <= '0;
      res_p2  <= '0;
    end else begin
      // p0: hundreds extracted, remainder below 100
      vld_p0 <= take;
      if (take) begin
        hund_p0 <= hund_c;
        rem_p0  <= rem_c;
      end
      // p1: tens preload from high nibble, ones accumulated
      vld_p1  <= vld_p0;
      hund_p1 <= hund_p0;
      tens_p1 <= {1'b0, rem_p0[6:4]};
      ones_p1 <= ones_c;
      // p2: ones carried into tens
      vld_p2 <= vld_p1;
      if (vld_p1) res_p2 <= {2'b00, hund_p1, tens_c, ones_fix_c};
    end
  end

  assign done   = vld_p2;
  assign result = res_p2;
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bcd8_core between NREQ requesters.
// Optional repeat-operand bypass enabled by defining BCD_LAST_HIT_EN.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*BIN_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [BCD_W-1:0]      resp_data,
  output logic [ID_W-1:0]       resp_id,
  input  logic                  resp_ready,
  output logic                  busy,
  output logic [15:0]           conv_count
);
  state_t           state;
  logic [ID_W-1:0]  rr_ptr, gnt_idx, nxt_ptr, id_lat;
  logic [BIN_W-1:0] gnt_op, op_lat;
  logic             gnt_found, grant, hit, core_start, core_done;
  logic [BCD_W-1:0] core_result;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_op    = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_found && req_valid[j] && ((int'(rr_ptr) + k) % NREQ) == j) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx == ID_W'(j)) gnt_op = req_data[j*BIN_W +: BIN_W];
    end
    nxt_ptr = (int'(gnt_idx) >= NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  assign grant = !rst && (state == IDLE) && gnt_found;

  always_comb begin
    for (int j = 0; j < NREQ; j++) req_ready[j] = grant && (gnt_idx == ID_W'(j));
  end

`ifdef BCD_LAST_HIT_EN
  logic [BIN_W-1:0] last_operand;
  logic [BCD_W-1:0] last_result;
  logic             last_valid;

  assign hit = last_valid && (gnt_op == last_operand);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
    end else if (core_done) begin
      last_valid   <= 1'b1;
      last_operand <= op_lat;
      last_result  <= core_result;
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign core_start = grant && !hit;
  assign busy       = (state != IDLE);

  bcd8_core u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .operand (gnt_op),
    .done    (core_done),
    .result  (core_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      conv_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            id_lat <= gnt_idx;
            op_lat <= gnt_op;
            rr_ptr <= nxt_ptr;
            if (hit) begin
`ifdef BCD_LAST_HIT_EN
              resp_data  <= last_result;
`endif
              resp_id    <= gnt_idx;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              conv_count <= conv_count + 16'd1;
              state      <= CONV;
            end
          end
        end
        CONV: begin
          if (core_done) begin
            resp_data  <= core_result;
            resp_id    <= id_lat;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a transaction-level reference model.
module tb_bcd_conv_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [11:0]       resp_data;
  logic [ID_W-1:0]   resp_id;
  logic              resp_ready = 1'b1;
  logic              busy;
  logic [15:0]       conv_count;

  bcd_conv_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  int          g_id[$];
  int          g_cyc[$];
  logic [11:0] r_data[$];
  int          r_id[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: phase 0 waiting, 1 converting, 2 response pending.
  int          m_phase = 0, m_cnt = 0, m_rr = 0, m_id = 0, m_gid = 0, m_op = 0, m_count = 0;
  logic        m_valid = 1'b0;
  logic [11:0] m_data = '0;
  int          l_op = 0;
  logic [11:0] l_res = '0;
  bit          l_v = 1'b0;
  bit          m_live = 1'b0;

  always @(negedge clk) begin : model
    int g;
    logic [NREQ-1:0] exp_rdy;
    g = -1;
    exp_rdy = '0;
    if (m_live && !rst && m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;

    if (m_live) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("resp_data", 32'(resp_data), 32'(m_data));
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("conv_count", 32'(conv_count), 32'(m_count));
    end

    for (int j = 0; j < NREQ; j++) begin
      if (req_valid[j] && req_ready[j]) begin
        g_id.push_back(j);
        g_cyc.push_back(cyc);
      end
    end
    if (resp_valid && resp_ready) begin
      r_data.push_back(resp_data);
      r_id.push_back(int'(resp_id));
    end

    if (rst) begin
      m_phase = 0; m_rr = 0; m_valid = 1'b0; m_data = '0; m_id = 0;
      m_count = 0; l_v = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      case (m_phase)
        0: if (g >= 0) begin
          m_op  = int'(req_data[g*8 +: 8]);
          m_gid = g;
          m_rr  = (g + 1) % NREQ;
`ifdef BCD_LAST_HIT_EN
          if (l_v && m_op == l_op) begin
            m_valid = 1'b1; m_data = l_res; m_id = g; m_phase = 2;
          end else begin
            m_count = (m_count + 1) % 65536; m_cnt = 3; m_phase = 1;
          end
`else
          m_count = (m_count + 1) % 65536; m_cnt = 3; m_phase = 1;
`endif
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_valid = 1'b1; m_data = dec3(m_op); m_id = m_gid;
            l_op = m_op; l_res = m_data; l_v = 1'b1;
            m_phase = 2;
          end
        end
        default: if (resp_ready) begin
          m_valid = 1'b0; m_phase = 0;
        end
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = '0; resp_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; lat = k; end
    end
  endtask

  task automatic single(input int r, input logic [7:0] d, input int exp_lat,
                        input logic [11:0] exp_d, input string nm);
    int lat;
    @(posedge clk); #1;
    req_valid = '0; req_valid[r] = 1'b1; req_data[r*8 +: 8] = d;
    @(negedge clk);
    chk({nm, " grant"}, 32'(req_ready), 32'(1 << r));
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(lat);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " data"}, 32'(resp_data), 32'(exp_d));
    chk({nm, " id"}, 32'(resp_id), 32'(r));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, gb, rb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_data", 32'(resp_data), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst conv_count", 32'(conv_count), 32'h0);

    single(2, 8'hFF, 4, 12'h255, "t1");
    chk("t1 conv_count", 32'(conv_count), 32'd1);

    // All requesters valid: round-robin order and spacing.
    do_reset();
    gb = g_id.size(); rb = r_data.size();
    req_data = {8'h63, 8'h0A, 8'h09, 8'h00};
    req_valid = 4'hF;
    for (int k = 0; k < 60 && g_id.size() < gb + 5; k++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(negedge clk);
    chk("t2 grant count", 32'(g_id.size() - gb), 32'd5);
    chk("t2 resp count", 32'(r_data.size() - rb), 32'd5);
    if (g_id.size() >= gb + 5 && r_data.size() >= rb + 5) begin
      chk("t2 g0", 32'(g_id[gb]), 32'd0);
      chk("t2 g1", 32'(g_id[gb+1]), 32'd1);
      chk("t2 g2", 32'(g_id[gb+2]), 32'd2);
      chk("t2 g3", 32'(g_id[gb+3]), 32'd3);
      chk("t2 g4", 32'(g_id[gb+4]), 32'd0);
      for (int i = 1; i < 5; i++) chk("t2 spacing", 32'(g_cyc[gb+i] - g_cyc[gb+i-1]), 32'd5);
      chk("t2 r0", 32'(r_data[rb]), 32'h000);
      chk("t2 r1", 32'(r_data[rb+1]), 32'h009);
      chk("t2 r2", 32'(r_data[rb+2]), 32'h010);
      chk("t2 r3", 32'(r_data[rb+3]), 32'h099);
      chk("t2 id3", 32'(r_id[rb+3]), 32'd3);
    end

    // Consumer stall with another requester waiting.
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 4'b0010; req_data[15:8] = 8'd57;
    @(negedge clk);
    chk("t3 grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b1000; req_data[31:24] = 8'd3;
    wait_resp(lat);
    chk("t3 latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3 hold valid", 32'(resp_valid), 32'd1);
      chk("t3 hold data", 32'(resp_data), 32'h057);
      chk("t3 hold id", 32'(resp_id), 32'd1);
      chk("t3 hold ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t3 handshake ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t3 next grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(negedge clk);

    // Reset in the middle of a conversion.
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b0001; req_data[7:0] = 8'd77;
    @(negedge clk);
    chk("t4 grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4 no resp", 32'(resp_valid), 32'd0);
    end
    chk("t4 conv_count", 32'(conv_count), 32'd0);
    chk("t4 resp_data", 32'(resp_data), 32'd0);
    chk("t4 busy", 32'(busy), 32'd0);
    single(0, 8'd100, 4, 12'h100, "t4b");

    // Same operand twice.
    do_reset();
    single(1, 8'd199, 4, 12'h199, "t5a");
`ifdef BCD_LAST_HIT_EN
    single(1, 8'd199, 1, 12'h199, "t5b");
    chk("t5 conv_count", 32'(conv_count), 32'd1);
`else
    single(1, 8'd199, 4, 12'h199, "t5b");
    chk("t5 conv_count", 32'(conv_count), 32'd2);
`endif

    // Every operand through requester 0.
    do_reset();
    for (int v = 0; v < 256; v++) single(0, 8'(v), 4, dec3(v), "t6");
    chk("t6 conv_count", 32'(conv_count), 32'd256);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
